// File: rtl/xor_seq_arbiter_pkg.sv
// Shared types and constants for the serial XOR sequencer/arbiter.
package xor_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1 so a WIDTH=1 counter still has one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_seq_arbiter_if.sv
// Request/result bundle for xor_seq_arbiter.
// Optional macro XOR_SEQ_PARITY_EN adds the parity output.
//
// Handshake rule for every channel here: a transfer happens on a rising
// clk edge where valid and ready are both high. valid never depends on
// ready; ready may depend combinationally on valid. Once raised, res_valid
// and its payload hold until the transfer.
interface xor_seq_arbiter_if
  import xor_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;
`ifdef XOR_SEQ_PARITY_EN
  logic             parity;
`endif

  // Producer/consumer side.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id,
    input  busy
`ifdef XOR_SEQ_PARITY_EN
    , input parity
`endif
  );

  // Sequencer side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id,
    output busy
`ifdef XOR_SEQ_PARITY_EN
    , output parity
`endif
  );

endinterface

// File: rtl/xor_seq_arbiter_cell.sv
// The single shared 1-bit XOR datapath element.
module xor_bit_cell (
  output logic s,
  input  logic a,
  input  logic b
);

  xor u_xor (s, a, b);

endmodule

// File: rtl/xor_seq_arbiter.sv
// Round-robin arbiter feeding one shared XOR cell, LSB first, over WIDTH
// cycles. Optional macro XOR_SEQ_PARITY_EN adds a result parity output.
module xor_seq_arbiter
  import xor_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  xor_seq_arbiter_if.slave   bus,
  output state_t             dbg_state
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             id_q;
  logic             xor_s;
  logic             grant0, grant1, accept;
  logic             rdy0, rdy1, res_vld;
`ifdef XOR_SEQ_PARITY_EN
  logic             par_q;
`endif

  // A lone requester wins regardless of the pointer; ties go to rr_ptr.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    res_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy0 = grant0;
        rdy1 = grant1;
        if (grant0 | grant1) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_vld = 1'b1;
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = rdy0 | rdy1;

  // Bit 0 of the shifting operand registers is always the bit being processed.
  xor_bit_cell u_cell (
    .s (xor_s),
    .a (a_q[0]),
    .b (b_q[0])
  );

  // Operand capture, serial shifting, and pointer update on result handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      id_q     <= 1'b0;
`ifdef XOR_SEQ_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q   <= rdy0 ? bus.req0_a : bus.req1_a;
        b_q   <= rdy0 ? bus.req0_b : bus.req1_b;
        id_q  <= rdy1;
        res_q <= '0;
        cnt_q <= '0;
`ifdef XOR_SEQ_PARITY_EN
        par_q <= 1'b0;
`endif
      end else if (state_q == ST_SHIFT) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        // New bit enters at the MSB; after WIDTH shifts bit i sits at i.
        res_q <= (res_q >> 1) | (WIDTH'(xor_s) << (WIDTH - 1));
        cnt_q <= cnt_q + CNT_W'(1);
`ifdef XOR_SEQ_PARITY_EN
        par_q <= par_q ^ xor_s;
`endif
      end
      if (res_vld & bus.res_ready) rr_ptr_q <= ~id_q;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = res_vld;
  assign bus.res_data   = res_vld ? res_q : '0;
  assign bus.res_id     = res_vld & id_q;
  assign bus.busy       = (state_q != ST_IDLE);
`ifdef XOR_SEQ_PARITY_EN
  assign bus.parity     = res_vld & par_q;
`endif
  assign dbg_state      = state_q;

endmodule

// File: doc/xor_seq_arbiter.md
Name: xor_seq_arbiter

Overview:
- Sequencer and arbiter for a single shared 1-bit XOR datapath element.
- Two requesters each submit a pair of WIDTH-bit operands (a, b).
- The block grants one requester at a time, round-robin, and computes s = a ^ b bit-serially, LSB first, through the one shared XOR cell.
- The result is returned on a valid/ready result channel tagged with the requester id.
- Sits between operand producers and the bitwise-logic datapath of the guide exercises.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req1_valid  input  1  requester 1 has operands
- req1_ready  output  1  requester 1 operands accepted this cycle
- req1_a  input  WIDTH  requester 1 operand a
- req1_b  input  WIDTH  requester 1 operand b
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  a ^ b
- res_id  output  1  requester that owns res_data
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE; rr_ptr=0 (requester 0 favoured); bit counter 0; operand/result registers 0; res_valid=0, res_data=0, res_id=0, busy=0, req0_ready=req1_ready=0.
- States:
  - IDLE: no operation in progress; waiting for a request.
  - SHIFT: serial XOR over WIDTH cycles.
  - DONE: holding the result.
- Arbitration (IDLE only):
  - grant0 = req0_valid & (!req1_valid | rr_ptr==0).
  - grant1 = req1_valid & (!req0_valid | rr_ptr==1).
  - reqN_ready = (state==IDLE) & grantN. Ready is combinational from the valids; valid must never depend on ready.
- Accept (cycle T, valid&ready):
  - Capture a, b and id into internal registers; clear the result register and counter; go to SHIFT.
  - Operands may change after T without effect.
- SHIFT:
  - Each cycle i = 0..WIDTH-1: result[i] <= a_reg[i] XOR b_reg[i], via the shared xor cell instance.
  - Counter increments; at i==WIDTH-1 go to DONE.
  - WIDTH=1 means exactly one SHIFT cycle.
- Latency: res_valid rises at cycle T+WIDTH+1 (T+9 for WIDTH=8).
- DONE:
  - res_valid=1; res_data and res_id are stable until the handshake.
  - On res_ready: go to IDLE next cycle and set rr_ptr = ~res_id.
  - res_ready held high before res_valid completes in the first DONE cycle.
- No new request is accepted in SHIFT or DONE. Earliest back-to-back accept is the cycle after the result handshake.
- Single requester: if only one valid is high, it is granted regardless of rr_ptr, so there is no starvation of a lone requester.
- Reset mid-operation: the in-flight operation is discarded with no res_valid pulse; all outputs take their reset values at the next edge.
- res_data is 0 whenever res_valid=0.

Optional Feature:
- Macro XOR_SEQ_PARITY_EN.
- Defined: adds output parity (1 bit). A parity accumulator is cleared on accept and XORed with each serial result bit in SHIFT. parity is valid with res_valid (even-count of ones gives 0); it is 0 otherwise and at reset.
- Undefined: no parity port and no accumulator logic.

Decomposition:
- Package xor_seq_pkg holds:
  - State encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default WIDTH.
  - Counter width function clog2.
- One sub-module: xor_bit_cell (output s, input a, b), a gate-level single xor primitive and the shared datapath element. It is instantiated exactly once.

Test Plan:
1. Reset, then req0 a=8'hA5 b=8'h0F for one accept -> req0_ready at T, res_valid at T+9, res_data=8'hAA, res_id=0, parity=0.
2. req0 (a=8'hFF, b=8'h00) and req1 (a=8'h12, b=8'h34) both valid after reset -> req0 served first (8'hFF, id 0, parity 0), then req1 (8'h26, id 1, parity 1).
3. res_ready low for 5 cycles in DONE -> res_valid, res_data and res_id held stable; both req ready low throughout; IDLE one cycle after res_ready rises.
4. rst asserted in SHIFT at bit 3 of a=8'hF0, b=8'h0F -> next cycle all outputs 0, no res_valid. A subsequent a=8'h5C, b=8'h5C gives 8'h00.
5. req1 alone valid for 3 consecutive operations (a=8'h01/8'h02/8'h04, b=8'h00) -> all served, ids 1, results 8'h01/8'h02/8'h04, each accept 1 cycle after the previous handshake.
6. WIDTH=1 build: a=1 b=1, then a=1 b=0 -> res_valid 2 cycles after each accept, results 0 then 1.
